iter_controller: RTL and testbench

- Parametrised successor to the fixed five-step datapath controller.
- Sequences a datapath through a programmable number of iterations, N, taken from the `n` port and latched at start.
- Adds a pause (stall) input, an abort input, an internal iteration counter, and zero-iteration handling.
- Drives the datapath's clear, count-enable and register-load strobes, and reports ready/done to the host.

---
 rtl/iter_controller.sv | 141 ++++++++++++++
 tb/tb_iter_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_controller.sv
// ---------------------------------------------------------------------------
// iter_controller
//
// Sequences a datapath through a programmable number of iterations N.
// The host holds start high to arm the controller. Dropping start launches
// the run with the value of n sampled on that cycle. The run can be stalled
// with pause and cancelled with abort. A run with N = 0 goes straight to DONE.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset
//   start   in   level: high arms, a falling level while armed launches
//   n       in   iteration count, sampled every cycle in IDLE/ARMED
//   pause   in   stalls the run (no strobes, no count advance)
//   abort   in   cancels the operation, returns to IDLE
//   ready   out  controller idle/armed, host may set up operands
//   done    out  run complete, held until next start or abort
//   c_en    out  datapath counter enable
//   reg_en  out  datapath register load enable
//   reset   out  datapath clear
//   count   out  iterations completed in the current run
//
// Handshake: the host talks to the controller with levels, not pulses.
// ready=1 means a new operation may be armed. done=1 stays high until the
// host raises start again (re-arm) or asserts abort. The datapath strobes
// c_en/reg_en are valid for exactly the cycles in which they are high.
// ---------------------------------------------------------------------------
module iter_controller #(
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] n,
  input  logic              pause,
  input  logic              abort,
  output logic              ready,
  output logic              done,
  output logic              c_en,
  output logic              reg_en,
  output logic              reset,
  output logic [ITER_W-1:0] count
);

  localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // state_q is the observable FSM state for assertions and debug probes.
  state_t            state_q;
  state_t            state_d;
  logic [ITER_W-1:0] n_lat;
  logic [ITER_W-1:0] count_d;
  logic              last_iter;

  // The run exits on the increment that brings count to n_lat, so count can
  // never pass n_lat and never wraps, even for n_lat = 2^ITER_W-1.
  assign last_iter = (count == (n_lat - ONE));

  // Next-state and count update.
  always_comb begin
    state_d = state_q;
    count_d = count;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        if (!start) begin
          count_d = '0;
          // Decide on the live n, which is the same value n_lat captures
          // on this edge.
          state_d = (n != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!pause) begin
          count_d = count + ONE;
          if (last_iter) state_d = DONE;
        end
      end
      DONE: begin
        if (start) state_d = ARMED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort overrides every transition. Only rst ranks higher.
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // Moore outputs. pause is the only input that reaches an output
  // combinationally: it gates the strobes during RUN.
  always_comb begin
    ready  = 1'b0;
    done   = 1'b0;
    c_en   = 1'b0;
    reg_en = 1'b0;
    reset  = 1'b0;
    case (state_q)
      IDLE, ARMED: begin
        ready = 1'b1;
        reset = 1'b1;
      end
      RUN: begin
        c_en   = !pause;
        reg_en = !pause;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      n_lat   <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      // n tracks the port while the host is setting up. It is frozen once
      // the run is launched, so changes on n during RUN have no effect.
      if (state_q == IDLE || state_q == ARMED) n_lat <= n;
    end
  end

endmodule

// File: tb/tb_iter_controller.sv
module tb_iter_controller;

  localparam int ITER_W = 4;
  localparam int W      = 5 + ITER_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ITER_W-1:0] n;
  logic              pause;
  logic              abort;
  logic              ready;
  logic              done;
  logic              c_en;
  logic              reg_en;
  logic              reset;
  logic [ITER_W-1:0] count;

  int total;
  int bad;

  typedef struct packed {
    logic              st;
    logic [ITER_W-1:0] nv;
    logic              ps;
    logic              ab;
    logic              rs;
  } stim_t;

  stim_t          stim_q[$];
  logic [W-1:0]   exp_q[$];

  iter_controller #(.ITER_W(ITER_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n),
    .pause  (pause),
    .abort  (abort),
    .ready  (ready),
    .done   (done),
    .c_en   (c_en),
    .reg_en (reg_en),
    .reset  (reset),
    .count  (count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors {ready, done, c_en, reg_en, reset, count}
  function automatic logic [W-1:0] v_idle(input logic [ITER_W-1:0] c);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c};
  endfunction

  function automatic logic [W-1:0] v_run(input logic [ITER_W-1:0] c, input logic p);
    return {1'b0, 1'b0, ~p, ~p, 1'b0, c};
  endfunction

  function automatic logic [W-1:0] v_done(input logic [ITER_W-1:0] c);
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c};
  endfunction

  function automatic logic [W-1:0] obs();
    return {ready, done, c_en, reg_en, reset, count};
  endfunction

  // Driver: queue one cycle of stimulus with the outputs expected in it.
  task automatic add(input logic st, input logic [ITER_W-1:0] nv, input logic ps,
                     input logic ab, input logic rs, input logic [W-1:0] e);
    stim_q.push_back({st, nv, ps, ab, rs});
    exp_q.push_back(e);
  endtask

  // Driver: apply inputs after the falling edge, settle, then sample.
  task automatic cyc(input stim_t s);
    @(negedge clk);
    start = s.st;
    n     = s.nv;
    pause = s.ps;
    abort = s.ab;
    rst   = s.rs;
    #1;
  endtask

  task automatic test_reset();
    stim_t s; logic [W-1:0] e; int i;
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, v_idle(4'd0));
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    // rst in the middle of a run
    add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_run(4'd0, 1'b0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, v_run(4'd1, 1'b0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL reset step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_basic_n5();
    stim_t s; logic [W-1:0] e; int i;
    for (int k = 0; k < 3; k++) add(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    for (int k = 0; k < 5; k++) add(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, v_run(ITER_W'(k), 1'b0));
    for (int k = 0; k < 10; k++) add(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, v_done(4'd5));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL basic_n5 step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_pause();
    stim_t s; logic [W-1:0] e; int i;
    logic [5:0] pat;
    logic [ITER_W-1:0] cnt;
    // n=4, pause on the 2nd and 3rd run cycles
    add(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, v_done(4'd5));
    add(1'b0, 4'd4, 1'b0, 1'b0, 1'b0, v_idle(4'd5));
    pat = 6'b000110;
    cnt = '0;
    for (int k = 0; k < 6; k++) begin
      add(1'b0, 4'd4, pat[k], 1'b0, 1'b0, v_run(cnt, pat[k]));
      if (!pat[k]) cnt = cnt + ITER_W'(1);
    end
    add(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, v_done(4'd4));
    // n=2, pause on the final iteration holds off DONE
    add(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, v_idle(4'd4));
    add(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, v_run(4'd0, 1'b0));
    add(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, v_run(4'd1, 1'b1));
    add(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, v_run(4'd1, 1'b1));
    add(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, v_run(4'd1, 1'b0));
    add(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, v_done(4'd2));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL pause step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_zero_and_max();
    stim_t s; logic [W-1:0] e; int i;
    add(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, v_done(4'd2));
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v_idle(4'd2));
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v_done(4'd0));
    add(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, v_done(4'd0));
    add(1'b0, 4'd15, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    for (int k = 0; k < 15; k++) add(1'b0, 4'd15, 1'b0, 1'b0, 1'b0, v_run(ITER_W'(k), 1'b0));
    add(1'b0, 4'd15, 1'b0, 1'b0, 1'b0, v_done(4'd15));
    add(1'b0, 4'd15, 1'b0, 1'b0, 1'b0, v_done(4'd15));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL zero_max step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_abort();
    stim_t s; logic [W-1:0] e; int i;
    // abort on the 3rd run cycle of n=7
    add(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, v_done(4'd15));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_idle(4'd15));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_run(4'd0, 1'b0));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_run(4'd1, 1'b0));
    add(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, v_run(4'd2, 1'b0));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    // abort in ARMED: two idle cycles with start low prove we left ARMED
    add(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b1, 4'd7, 1'b0, 1'b1, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    // abort together with start in DONE goes to IDLE, not ARMED
    add(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, v_done(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    // rst and abort together in RUN
    add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_run(4'd0, 1'b0));
    add(1'b0, 4'd3, 1'b0, 1'b1, 1'b1, v_run(4'd1, 1'b0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL abort step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; logic [W-1:0] e; int i;
    add(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_idle(4'd0));
    for (int k = 0; k < 3; k++) add(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, v_run(ITER_W'(k), 1'b0));
    // re-arm from DONE with n=2, then change n and raise start mid-run
    add(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, v_done(4'd3));
    add(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, v_idle(4'd3));
    add(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, v_run(4'd0, 1'b0));
    add(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, v_run(4'd1, 1'b0));
    add(1'b0, 4'd9, 1'b0, 1'b0, 1'b0, v_done(4'd2));
    add(1'b0, 4'd9, 1'b0, 1'b0, 1'b0, v_done(4'd2));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  task automatic test_random_pause();
    stim_t s; logic [W-1:0] e; int i;
    logic [ITER_W-1:0] nn, k, prev;
    logic p;
    prev = 4'd2;
    for (int r = 0; r < 4; r++) begin
      nn = ITER_W'($urandom_range(1, 15));
      add(1'b1, nn, 1'b0, 1'b0, 1'b0, v_done(prev));
      add(1'b0, nn, 1'b0, 1'b0, 1'b0, v_idle(prev));
      k = '0;
      while (k != nn) begin
        p = 1'($urandom_range(0, 1));
        add(1'b0, ITER_W'($urandom_range(0, 15)), p, 1'b0, 1'b0, v_run(k, p));
        if (!p) k = k + ITER_W'(1);
      end
      add(1'b0, nn, 1'b0, 1'b0, 1'b0, v_done(nn));
      prev = nn;
    end
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); cyc(s); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL random_pause step %0d: got %b want %b", i, obs(), e);
      end
      i++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    pause = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    test_reset();
    test_basic_n5();
    test_pause();
    test_zero_and_max();
    test_abort();
    test_back_to_back();
    test_random_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
